// File: rtl/mem_stream_ctrl_if.sv
// Bus bundle for mem_stream_ctrl: load port, stream command and the
// valid/ready output stream. The controller takes the master side; the
// environment (loader, commander and consumer) takes the slave side.
interface mem_stream_ctrl_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;

  modport master (
    input  wr_en, wr_addr, wr_data, start, base_addr, count, out_ready,
    output out_valid, out_data, out_addr, busy, done
  );

  modport slave (
    output wr_en, wr_addr, wr_data, start, base_addr, count, out_ready,
    input  out_valid, out_data, out_addr, busy, done
  );
endinterface

// File: rtl/mem_stream_ctrl.sv
// mem_stream_ctrl: byte-wide DEPTH-entry memory with a load port and a
// sequential read-out engine. A start command streams count consecutive
// locations (wrapping modulo DEPTH) over a valid/ready handshake.
// All outputs are registered; the memory is read-before-write, so a load of
// out_data on the same edge as a write to that address returns the old byte.
module mem_stream_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input logic               clk,
  input logic               rst,
  mem_stream_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  state_t        state_r;
  state_t        next_state_s;

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] ptr_r;
  logic [AW:0]   remaining_r;
  logic [DW-1:0] out_data_r;
  logic [AW-1:0] out_addr_r;
  logic          out_valid_r;
  logic          busy_r;
  logic          done_r;

  logic          handshake_s;
  logic          load_first_s;
  logic          advance_s;
  logic [AW-1:0] ptr_next_s;
  logic [AW:0]   count_eff_s;

  // Clamp the requested length: 0 and anything above DEPTH mean a full sweep.
  always_comb begin
    count_eff_s = bus.count;
    if ((bus.count == {(AW+1){1'b0}}) || (bus.count > DEPTH_W)) begin
      count_eff_s = DEPTH_W;
    end else begin
      count_eff_s = bus.count;
    end
  end

  // Next read pointer, wrapping naturally in AW bits.
  always_comb begin
    ptr_next_s = ptr_r + ONE_A;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode plus the load/advance strobes for the datapath.
  always_comb begin
    next_state_s = state_r;
    handshake_s  = 1'b0;
    load_first_s = 1'b0;
    advance_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          load_first_s = 1'b1;
          next_state_s = STREAM;
        end else begin
          next_state_s = IDLE;
        end
      end
      STREAM: begin
        handshake_s = out_valid_r & bus.out_ready;
        if (handshake_s) begin
          if (remaining_r > ONE_W) begin
            advance_s    = 1'b1;
            next_state_s = STREAM;
          end else begin
            next_state_s = DONE;
          end
        end else begin
          next_state_s = STREAM;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      out_valid_r <= (next_state_s == STREAM);
      busy_r      <= (next_state_s != IDLE);
      done_r      <= (next_state_s == DONE);
    end
  end

  // Pointer, word counter and output word; held whenever no handshake occurs
  // so the presented word never changes under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r       <= {AW{1'b0}};
      remaining_r <= {(AW+1){1'b0}};
      out_data_r  <= {DW{1'b0}};
      out_addr_r  <= {AW{1'b0}};
    end else if (load_first_s) begin
      ptr_r       <= bus.base_addr;
      remaining_r <= count_eff_s;
      out_data_r  <= mem_r[bus.base_addr];
      out_addr_r  <= bus.base_addr;
    end else if (advance_s) begin
      ptr_r       <= ptr_next_s;
      remaining_r <= remaining_r - ONE_W;
      out_data_r  <= mem_r[ptr_next_s];
      out_addr_r  <= ptr_next_s;
    end else if (handshake_s) begin
      remaining_r <= remaining_r - ONE_W;
    end else begin
      remaining_r <= remaining_r;
    end
  end

  // Storage array; writes are accepted in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (bus.wr_en) begin
      mem_r[bus.wr_addr] <= bus.wr_data;
    end else begin
      mem_r[bus.wr_addr] <= mem_r[bus.wr_addr];
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_addr  = out_addr_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: doc/mem_stream_ctrl.md
# mem_stream_ctrl

Byte-wide 8-entry memory with a write port for loading and a sequential read-out engine. On a start command it streams a range of consecutive locations to a downstream consumer over a valid/ready handshake, wrapping modulo depth. It is the synthesizable read stage that feeds memory contents, byte by byte, to the next block in the datapath.

## Interface
- DEPTH, 8, number of memory entries (power of two)
- AW, 3, address width, log2(DEPTH)
- DW, 8, data width in bits
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  write strobe for the load port
- wr_addr  input  AW  write address
- wr_data  input  DW  write data
- start  input  1  begin a stream; sampled only in IDLE
- base_addr  input  AW  first address of the stream; sampled with start
- count  input  AW+1  words to stream; 0 means DEPTH; values above DEPTH are clamped to DEPTH
- out_valid  output  1  out_data/out_addr hold a word
- out_ready  input  1  consumer accepts the word
- out_data  output  DW  streamed byte
- out_addr  output  AW  address of out_data
- busy  output  1  high in STREAM and DONE
- done  output  1  one-cycle pulse after the final word is accepted

## Operation
- States: IDLE, STREAM, DONE.
- IDLE: start=1 latches ptr=base_addr, remaining=count (0 or >DEPTH → DEPTH), loads out_data=mem[base_addr], out_addr=base_addr, goes to STREAM.
- STREAM: out_valid=1. A handshake (out_valid & out_ready) consumes the word.
  - remaining>1: ptr=(ptr+1) mod DEPTH, out_data/out_addr reload from the new ptr, remaining-1, stay in STREAM.
  - remaining==1: go to DONE, out_valid drops.
  - No handshake: out_data/out_addr held stable, even if that location is rewritten.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored; base_addr/count are not re-sampled.
- Writes are accepted in any state. The memory is read-before-write: if a write and an out_data load hit the same address on the same edge, out_data gets the old value. Later words see the new value.
- Address arithmetic is AW bits wide and wraps DEPTH-1 → 0.
- Reset: state=IDLE, out_valid=0, out_data=0, out_addr=0, busy=0, done=0, ptr=0, remaining=0, all memory entries=0. Reset mid-stream aborts immediately with no done pulse.

## Timing
- start sampled at edge N → out_valid, busy high from edge N; first word visible in cycle N+1.
- With out_ready held high: one word per cycle; k words occupy k consecutive cycles.
- Final handshake at edge M → out_valid low and done high from edge M, done low from M+1, busy low from M+1.
- A new start is accepted the cycle after done (IDLE); minimum gap between streams is one cycle.
- A write at edge W is visible to any out_data load at edge W+1 or later.

## Test plan
- Reset, then write 0x11,0x22,…,0x88 to addresses 0–7; start base=0, count=8, out_ready=1 → eight consecutive words 0x11..0x88 with out_addr 0..7; done one cycle after the last word; busy low thereafter.
- Wrap: start base=6, count=4 → out_addr 6,7,0,1, data 0x77,0x88,0x11,0x22.
- Backpressure: base=2, count=3, out_ready toggles 1,0,0,1,1 → data 0x33 accepted, 0x44 held stable two cycles then accepted, 0x55 accepted; done once.
- count=0 with base=5 → 8 words at addresses 5,6,7,0..4. start pulsed mid-stream with base=0 → ignored, sequence unchanged.
- Write collision: stream base=0, count=2, out_ready=0, write address 0=0xAA while held → out_data stays 0x11. Write address 1=0xBB on the same edge as the first handshake → second word is old 0x22.
- Assert rst mid-stream after the 3rd word → out_valid, busy, done go 0 immediately, no done pulse, memory reads back 0 on the next stream.
